seq_decoder: RTL
================

SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 Parameter DATA_W, default 8: GPR/ALU data width and width of each instruction argument field.
REQ-002 Parameter REG_AW, default 3: GPR address width; register index taken from argument bits [REG_AW-1:0].
REQ-003 Parameter PC_W, default 8 (SHALL be <= DATA_W): program counter width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 run  in  1  advance enable; sampled only in FETCH.
REQ-007 rom_addr  out  PC_W  instruction address.
REQ-008 rom_data  in  8+2*DATA_W  {opcode[7:0], arg_a, arg_b}; synchronous ROM, valid one cycle after rom_addr.
REQ-009 gpr_w_enable/gpr_w_addr/gpr_w_data  out  1/REG_AW/DATA_W  register-file write port.
REQ-010 gpr_r_addr_a, gpr_r_addr_b  out  REG_AW; gpr_r_data_a, gpr_r_data_b  in  DATA_W  combinational read ports.
REQ-011 alu_operation  out  5; alu_A, alu_B  out  DATA_W; alu_C  in  DATA_W; alu_carry  in  1.
REQ-012 halted  out  1  high while in HALT state.
REQ-013 illegal_op  out  1  sticky: unknown opcode seen since reset.

Function
REQ-014 FSM states FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; HALT terminal until reset.
REQ-015 FETCH: rom_addr=pc; if run=1 go DECODE, else remain in FETCH with no outputs changed.
REQ-016 DECODE: latch rom_data into instruction register IR at end of cycle.
REQ-017 EXECUTE: drive GPR read addresses and ALU inputs/operation combinationally from IR; latch write data into result register at end of cycle.
REQ-018 WRITEBACK: gpr_w_enable=1 for exactly this one cycle for writing opcodes, gpr_w_data=result register; pc updated at end of cycle.
REQ-019 Opcodes NOP, LD, LDR, ADD, SUB, INC, DEC, CLR, SET: same semantics as the existing single-cycle decoder (LD rd<-r[arg_b]; LDR rd<-arg_b; ADD/SUB rd<-rd op rs; INC/DEC rd<-rd+/-1; CLR rd<-0; SET rd<-all ones), widths scaled to DATA_W.
REQ-020 New opcodes JMP, JZ, JC, HLT, codes defined in the global parameter include file alongside existing opcodes.
REQ-021 JMP: pc<-arg_a[PC_W-1:0] in WRITEBACK; no GPR write.
REQ-022 HLT: from WRITEBACK enter HALT; pc unchanged; halted=1; all write enables 0.
REQ-023 Non-branch instructions: pc<-pc+1 modulo 2^PC_W (all-ones wraps to 0).
REQ-024 Unknown opcode: executed as NOP (pc+1), illegal_op set to 1 and held until reset.
REQ-025 All outputs not used by the current state/opcode SHALL be 0 (no latches); gpr_w_enable=0 in every state except WRITEBACK.
REQ-026 Throughput: exactly 4 clk cycles per instruction when run=1 (excluding HALT).

Reset
REQ-027 rst asserted asynchronously forces: state=FETCH, pc=0, IR=0, result=0, flags=0, illegal_op=0, halted=0, gpr_w_enable=0 immediately, including mid-WRITEBACK (write aborted).
REQ-028 After rst deassert, first rom_addr=0 in the first cycle.

Configuration
REQ-029 Macro SEQ_DECODER_FLAGS_EN defined: zero flag (result==0) and carry flag (alu_carry) registered in WRITEBACK of ADD/SUB/INC/DEC only; JZ/JC set pc<-arg_a[PC_W-1:0] when Z/C=1, else pc+1.
REQ-030 Macro undefined: no flag registers synthesised; JZ and JC behave as NOP (pc+1, illegal_op unaffected).

Verification
REQ-031 Reset, run=1, ROM[0]=LDR r2,0x5A -> gpr write r2=0x5A in cycle 4 only; rom_addr=1 in cycle 5.
REQ-032 LDR r1,0xFF; INC r1; JZ 0x10 (flags enabled) -> r1=0x00, C=1, Z=1, rom_addr=0x10 next FETCH; flags disabled -> rom_addr=3.
REQ-033 run=0 held 5 cycles in FETCH -> rom_addr stable, gpr_w_enable=0 throughout; resumes with 4-cycle timing.
REQ-034 pc=0xFF executing NOP -> next rom_addr=0x00; opcode 0xEE -> illegal_op=1, persists through later valid instructions.
REQ-035 HLT at address 3 -> halted=1, rom_addr=3 stays, no writes for 20 cycles; rst -> halted=0, rom_addr=0.
REQ-036 rst asserted mid-WRITEBACK of ADD -> gpr_w_enable drops before next clk edge; target register unchanged.

Source files
------------

// File: rtl/seq_decoder_if.sv
// Bus bundle for seq_decoder: instruction ROM, GPR file ports, ALU ports and status.
// The master modport is the decoder side; slave is the surrounding datapath.
interface seq_decoder_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int PC_W   = 8
);
    logic                    run;
    logic [PC_W-1:0]         rom_addr;
    logic [8+2*DATA_W-1:0]   rom_data;
    logic                    gpr_w_enable;
    logic [REG_AW-1:0]       gpr_w_addr;
    logic [DATA_W-1:0]       gpr_w_data;
    logic [REG_AW-1:0]       gpr_r_addr_a;
    logic [REG_AW-1:0]       gpr_r_addr_b;
    logic [DATA_W-1:0]       gpr_r_data_a;
    logic [DATA_W-1:0]       gpr_r_data_b;
    logic [4:0]              alu_operation;
    logic [DATA_W-1:0]       alu_A;
    logic [DATA_W-1:0]       alu_B;
    logic [DATA_W-1:0]       alu_C;
    logic                    alu_carry;
    logic                    halted;
    logic                    illegal_op;

    modport master (
        input  run, rom_data, gpr_r_data_a, gpr_r_data_b, alu_C, alu_carry,
        output rom_addr, gpr_w_enable, gpr_w_addr, gpr_w_data, gpr_r_addr_a, gpr_r_addr_b,
               alu_operation, alu_A, alu_B, halted, illegal_op
    );

    modport slave (
        output run, rom_data, gpr_r_data_a, gpr_r_data_b, alu_C, alu_carry,
        input  rom_addr, gpr_w_enable, gpr_w_addr, gpr_w_data, gpr_r_addr_a, gpr_r_addr_b,
               alu_operation, alu_A, alu_B, halted, illegal_op
    );
endinterface

// File: rtl/seq_decoder.sv
// Four-cycle sequential instruction decoder: FETCH -> DECODE -> EXECUTE -> WRITEBACK, HALT terminal.
// Define SEQ_DECODER_FLAGS_EN to add Z/C flags and make JZ/JC conditional branches.
module seq_decoder #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int PC_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_decoder_if.master bus
);
    localparam int IR_W = 8 + 2*DATA_W;

    localparam logic [7:0] OP_NOP = 8'h00, OP_LD  = 8'h01, OP_LDR = 8'h02, OP_ADD = 8'h03,
                           OP_SUB = 8'h04, OP_INC = 8'h05, OP_DEC = 8'h06, OP_CLR = 8'h07,
                           OP_SET = 8'h08, OP_JMP = 8'h09, OP_JZ  = 8'h0A, OP_JC  = 8'h0B,
                           OP_HLT = 8'h0C;
    localparam logic [4:0] ALU_ADD = 5'd1, ALU_SUB = 5'd2;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    state_t              r_state, w_next;
    logic [PC_W-1:0]     r_pc;
    logic [IR_W-1:0]     r_ir;
    logic [DATA_W-1:0]   r_result;
    logic                r_illegal;
    logic [DATA_W-1:0]   w_exec_data;

    logic [7:0]          w_op;
    logic [DATA_W-1:0]   w_arg_a, w_arg_b;
    logic [REG_AW-1:0]   w_rd, w_rs;
    logic                w_writes, w_known, w_arith;
    logic [PC_W-1:0]     w_pc_inc, w_target;

    assign w_op     = r_ir[IR_W-1 -: 8];
    assign w_arg_a  = r_ir[2*DATA_W-1 -: DATA_W];
    assign w_arg_b  = r_ir[DATA_W-1:0];
    assign w_rd     = w_arg_a[REG_AW-1:0];
    assign w_rs     = w_arg_b[REG_AW-1:0];
    assign w_writes = (w_op >= OP_LD) && (w_op <= OP_SET);
    assign w_known  = (w_op <= OP_HLT);
    assign w_arith  = (w_op >= OP_ADD) && (w_op <= OP_DEC);
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_target = w_arg_a[PC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (bus.run) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = S_WB;
            S_WB:     w_next = (w_op == OP_HLT) ? S_HALT : S_FETCH;
            default:  w_next = S_HALT;
        endcase
    end

    always_comb begin
        bus.rom_addr      = '0;
        bus.gpr_w_enable  = 1'b0;
        bus.gpr_w_addr    = '0;
        bus.gpr_w_data    = '0;
        bus.gpr_r_addr_a  = '0;
        bus.gpr_r_addr_b  = '0;
        bus.alu_operation = '0;
        bus.alu_A         = '0;
        bus.alu_B         = '0;
        bus.halted        = (r_state == S_HALT);
        bus.illegal_op    = r_illegal;
        w_exec_data       = '0;
        case (r_state)
            S_FETCH, S_HALT: bus.rom_addr = r_pc;
            S_EXEC: begin
                bus.gpr_r_addr_a = w_rd;
                bus.gpr_r_addr_b = w_rs;
                case (w_op)
                    OP_ADD: begin bus.alu_operation = ALU_ADD; bus.alu_A = bus.gpr_r_data_a; bus.alu_B = bus.gpr_r_data_b; end
                    OP_SUB: begin bus.alu_operation = ALU_SUB; bus.alu_A = bus.gpr_r_data_a; bus.alu_B = bus.gpr_r_data_b; end
                    OP_INC: begin bus.alu_operation = ALU_ADD; bus.alu_A = bus.gpr_r_data_a; bus.alu_B = DATA_W'(1); end
                    OP_DEC: begin bus.alu_operation = ALU_SUB; bus.alu_A = bus.gpr_r_data_a; bus.alu_B = DATA_W'(1); end
                    default: ;
                endcase
                case (w_op)
                    OP_LD:                          w_exec_data = bus.gpr_r_data_b;
                    OP_LDR:                         w_exec_data = w_arg_b;
                    OP_ADD, OP_SUB, OP_INC, OP_DEC: w_exec_data = bus.alu_C;
                    OP_SET:                         w_exec_data = '1;
                    default:                        w_exec_data = '0;
                endcase
            end
            S_WB: begin
                bus.gpr_w_enable = w_writes;
                bus.gpr_w_addr   = w_writes ? w_rd : '0;
                bus.gpr_w_data   = w_writes ? r_result : '0;
            end
            default: ;
        endcase
    end

`ifdef SEQ_DECODER_FLAGS_EN
    // Carry is only valid while the ALU is driven in EXECUTE, so stage it until WRITEBACK commits flags.
    logic r_carry_stage, r_z, r_c;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry_stage <= 1'b0;
            r_z           <= 1'b0;
            r_c           <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_carry_stage <= bus.alu_carry;
        end else if (r_state == S_WB && w_arith) begin
            r_z <= (r_result == '0);
            r_c <= r_carry_stage;
        end
    end
`else
    logic w_unused_carry;
    assign w_unused_carry = bus.alu_carry ^ w_arith;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_DECODE: r_ir <= bus.rom_data;
                S_EXEC: begin
                    r_result <= w_exec_data;
                    if (!w_known) r_illegal <= 1'b1;
                end
                S_WB: begin
                    case (w_op)
                        OP_JMP: r_pc <= w_target;
`ifdef SEQ_DECODER_FLAGS_EN
                        OP_JZ:  r_pc <= r_z ? w_target : w_pc_inc;
                        OP_JC:  r_pc <= r_c ? w_target : w_pc_inc;
`endif
                        OP_HLT: r_pc <= r_pc;
                        default: r_pc <= w_pc_inc;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule
